pwm_capture: RTL

//  Register-mapped PWM input decoder, the receive-side counterpart of the PWM generator. Samples an

---
 rtl/pwm_capture_if.sv | 23 ++
 rtl/pwm_capture.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - register strobe bus between the host and the PWM capture block
interface pwm_capture_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                            cap_reg_wren;
    logic                            cap_reg_rden;
    logic [C_S_AXI_DATA_WIDTH-1:0]   cap_reg_data;

    modport master (
        output S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_ARADDR, cap_reg_wren, cap_reg_rden,
        input  cap_reg_data
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_ARADDR, cap_reg_wren, cap_reg_rden,
        output cap_reg_data
    );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input decoder measuring period and high time in clock cycles
module pwm_capture #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic         S_AXI_ACLK,
    input  logic         S_AXI_ARESET,
    input  logic         pwm_in,
    pwm_capture_if.slave bus,
    output logic         irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int NB = DW / 8;
    localparam logic [DW-1:0] TIMEOUT_RST = DW'(32'h05F5E100);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t        state;
    logic [2:0]    ctrl;
    logic [DW-1:0] timeout;
    logic [DW-1:0] period;
    logic [DW-1:0] high_time;
    logic [2:0]    status;
    logic [DW-1:0] cnt;
    logic [DW-1:0] hi;
    logic [DW-1:0] hi_lat;
    logic          sync1;
    logic          sync2;
    logic          lvl_d;

    logic          lvl;
    logic          rise;
    logic          fall;
    logic          enable;
    logic          cap_evt;
    logic          tmo_evt;
    logic [5:0]    wr_off;
    logic [5:0]    rd_off;
    logic [2:0]    status_set;
    logic [2:0]    status_clr;
    logic [DW-1:0] rd_mux;
    logic          unused_addr_bits;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [NB-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Counters stick at all-ones so a very long period never reads back as a short one
    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (v == '1) ? v : v + DW'(1);
    endfunction

    always_comb begin
        wr_off     = bus.S_AXI_AWADDR[7:2];
        rd_off     = bus.S_AXI_ARADDR[7:2];
        enable     = ctrl[0];
        lvl        = sync2 ^ ctrl[1];
        rise       = lvl & ~lvl_d;
        fall       = ~lvl & lvl_d;
        cap_evt    = enable && (state == MEAS) && rise;
        tmo_evt    = enable && (state == MEAS) && !rise && (timeout != '0) && (cnt == timeout);
        status_set = {cap_evt & status[0], tmo_evt, cap_evt};
        status_clr = (bus.cap_reg_wren && wr_off == 6'd4 && bus.S_AXI_WSTRB[0])
                     ? bus.S_AXI_WDATA[2:0] : 3'b000;
        unused_addr_bits = ^{bus.S_AXI_AWADDR[AW-1:8], bus.S_AXI_AWADDR[1:0],
                             bus.S_AXI_ARADDR[AW-1:8], bus.S_AXI_ARADDR[1:0]};
        case (rd_off)
            6'd0:    rd_mux = DW'(ctrl);
            6'd1:    rd_mux = timeout;
            6'd2:    rd_mux = period;
            6'd3:    rd_mux = high_time;
            6'd4:    rd_mux = DW'(status);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state            <= IDLE;
            ctrl             <= 3'b000;
            timeout          <= TIMEOUT_RST;
            period           <= '0;
            high_time        <= '0;
            status           <= 3'b000;
            cnt              <= '0;
            hi               <= '0;
            hi_lat           <= '0;
            sync1            <= 1'b0;
            sync2            <= 1'b0;
            lvl_d            <= 1'b0;
            irq              <= 1'b0;
            bus.cap_reg_data <= '0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            lvl_d <= lvl;

            // The read mux sees pre-write register values, so a colliding write is not visible yet
            if (bus.cap_reg_rden) begin
                bus.cap_reg_data <= rd_mux;
            end
            if (bus.cap_reg_wren && wr_off == 6'd0 && bus.S_AXI_WSTRB[0]) begin
                ctrl <= bus.S_AXI_WDATA[2:0];
            end
            if (bus.cap_reg_wren && wr_off == 6'd1) begin
                timeout <= merge_bytes(timeout, bus.S_AXI_WDATA, bus.S_AXI_WSTRB);
            end

            status <= (status & ~status_clr) | status_set;
            irq    <= ctrl[2] & (status[0] | status[1]);

            if (!enable) begin
                state  <= IDLE;
                cnt    <= '0;
                hi     <= '0;
                hi_lat <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= '0;
                        hi    <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            state <= MEAS;
                            cnt   <= DW'(1);
                            hi    <= DW'(1);
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            period    <= cnt;
                            high_time <= hi_lat;
                            cnt       <= DW'(1);
                            hi        <= DW'(1);
                        end else if (tmo_evt) begin
                            state <= ARM;
                            cnt   <= '0;
                            hi    <= '0;
                        end else begin
                            cnt <= sat_inc(cnt);
                            if (lvl) begin
                                hi <= sat_inc(hi);
                            end
                            if (fall) begin
                                hi_lat <= hi;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
